// File: rtl/gray_pkg.sv
// Shared types and the Gray-to-binary helper for the Gray stream decoder.
// Combinational only; no backpressure.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } state_t;

  // Narrower codes are zero-extended by the caller; leading zeros leave the low bits unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_stream_decoder_if.sv
// Sample-in / decoded-out bundle of the Gray stream decoder.
// No backpressure: gray_valid is a strobe and bin_valid is a one-cycle pulse.
interface gray_stream_decoder_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0]     gray_in;
  logic                 gray_valid;
  logic                 err_clr;
  logic [WIDTH-1:0]     bin_out;
  logic                 bin_valid;
  logic                 step_up;
  logic                 step_down;
  logic                 step_err;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output gray_in, gray_valid, err_clr,
    input  bin_out, bin_valid, step_up, step_down, step_err, locked, err_count
  );

  modport slave (
    input  gray_in, gray_valid, err_clr,
    output bin_out, bin_valid, step_up, step_down, step_err, locked, err_count
  );
endinterface

// File: rtl/gray_step_classifier.sv
// Classifies a new binary sample against the previous one: hold, +1, -1 or jump.
// Combinational, zero latency; no backpressure.
module gray_step_classifier #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] new_val,
  output logic             is_hold,
  output logic             is_up,
  output logic             is_down,
  output logic             is_err
);
  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] prev_dec;

  assign prev_inc = prev + WIDTH'(1);
  assign prev_dec = prev - WIDTH'(1);

  // Priority keeps the flags one-hot even when +1 and -1 coincide (WIDTH=1).
  assign is_hold = (new_val == prev);
  assign is_up   = !is_hold && (new_val == prev_inc);
  assign is_down = !is_hold && !is_up && (new_val == prev_dec);
  assign is_err  = !(is_hold || is_up || is_down);
endmodule

// File: rtl/gray_stream_decoder.sv
// Decodes a Gray sample stream to binary, flags steps/jumps, tracks lock and counts errors.
// Latency 1 cycle from accepted sample to bin_valid; no backpressure (every valid is taken).
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int ERR_CNT_W   = 8,
  parameter int RELOCK_ERRS = 3
) (
  input logic                  clk,
  input logic                  rst,
  gray_stream_decoder_if.slave bus
);
  localparam int CONSEC_W = 4;

  state_t               state_q, state_d;
  logic [CONSEC_W-1:0]  consec_q, consec_d, consec_inc;
  logic [WIDTH-1:0]     prev_q, prev_d, decoded;
  logic                 vld_q, vld_d;
  logic                 up_q, up_d, dn_q, dn_d, err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic                 is_hold, is_up, is_down, is_err;

  assign decoded    = WIDTH'(gray2bin(GRAY_MAX_W'(bus.gray_in)));
  assign consec_inc = consec_q + CONSEC_W'(1);

  gray_step_classifier #(.WIDTH(WIDTH)) u_classifier (
    .prev    (prev_q),
    .new_val (decoded),
    .is_hold (is_hold),
    .is_up   (is_up),
    .is_down (is_down),
    .is_err  (is_err)
  );

  always_comb begin
    state_d  = state_q;
    consec_d = consec_q;
    prev_d   = prev_q;
    vld_d    = 1'b0;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    err_d    = 1'b0;
    if (bus.gray_valid) begin
      prev_d = decoded;
      vld_d  = 1'b1;
      if (state_q == UNLOCKED) begin
        state_d  = LOCKED;
        consec_d = '0;
      end else if (is_hold) begin
        consec_d = '0;
      end else if (is_up) begin
        up_d     = 1'b1;
        consec_d = '0;
      end else if (is_down) begin
        dn_d     = 1'b1;
        consec_d = '0;
      end else if (is_err) begin
        err_d = 1'b1;
        if (consec_inc == CONSEC_W'(RELOCK_ERRS)) begin
          state_d  = UNLOCKED;
          consec_d = '0;
        end else begin
          consec_d = consec_inc;
        end
      end
    end
    // Clear takes effect before a same-cycle error is counted.
    cnt_base = bus.err_clr ? '0 : cnt_q;
    cnt_d    = (err_d && !(&cnt_base)) ? cnt_base + ERR_CNT_W'(1) : cnt_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= UNLOCKED;
      consec_q <= '0;
      prev_q   <= '0;
      vld_q    <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
      prev_q   <= prev_d;
      vld_q    <= vld_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.bin_out   = prev_q;
  assign bus.bin_valid = vld_q;
  assign bus.step_up   = up_q;
  assign bus.step_down = dn_q;
  assign bus.step_err  = err_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_gray_stream_decoder.sv
// Bench for gray_stream_decoder (WIDTH=4, ERR_CNT_W=8, RELOCK_ERRS=3): vector table plus
// hand sequences for counter saturation and asynchronous reset.
module tb_gray_stream_decoder;

  typedef struct {
    logic [3:0] g;
    logic       v;
    logic       clr;
    logic [3:0] bin;
    logic       vld;
    logic       up;
    logic       dn;
    logic       err;
    logic       lk;
    logic [7:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_stream_decoder_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();

  gray_stream_decoder #(.WIDTH(4), .ERR_CNT_W(8), .RELOCK_ERRS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  vec_t exp_q[$];
  vec_t tbl[32];

  function automatic vec_t mk(int g, int v, int c, int b, int vld, int up, int dn,
                              int er, int lk, int cnt);
    vec_t r;
    r.g   = 4'(g);
    r.v   = 1'(v);
    r.clr = 1'(c);
    r.bin = 4'(b);
    r.vld = 1'(vld);
    r.up  = 1'(up);
    r.dn  = 1'(dn);
    r.err = 1'(er);
    r.lk  = 1'(lk);
    r.cnt = 8'(cnt);
    return r;
  endfunction

  task automatic chk(string nm, int idx, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s #%0d got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic compare(int idx, vec_t e);
    chk("bin_out",   idx, int'(bus.bin_out),   int'(e.bin));
    chk("bin_valid", idx, int'(bus.bin_valid), int'(e.vld));
    chk("step_up",   idx, int'(bus.step_up),   int'(e.up));
    chk("step_down", idx, int'(bus.step_down), int'(e.dn));
    chk("step_err",  idx, int'(bus.step_err),  int'(e.err));
    chk("locked",    idx, int'(bus.locked),    int'(e.lk));
    chk("err_count", idx, int'(bus.err_count), int'(e.cnt));
  endtask

  task automatic do_step(int idx, vec_t v);
    vec_t e;
    @(negedge clk);
    bus.gray_in    = v.g;
    bus.gray_valid = v.v;
    bus.err_clr    = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare(idx, e);
  endtask

  initial begin
    int seq[4];
    int ecnt;
    int b;
    int g;
    bit er;

    //            gray     v  c  bin vld up dn err lk cnt
    tbl[0]  = mk('b0000, 1, 0,  0, 1, 0, 0, 0, 1, 0);
    tbl[1]  = mk('b0001, 1, 0,  1, 1, 1, 0, 0, 1, 0);
    tbl[2]  = mk('b0011, 1, 0,  2, 1, 1, 0, 0, 1, 0);
    tbl[3]  = mk('b0010, 1, 0,  3, 1, 1, 0, 0, 1, 0);
    tbl[4]  = mk('b0000, 0, 0,  3, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk('b0010, 1, 0,  3, 1, 0, 0, 0, 1, 0);
    tbl[6]  = mk('b0011, 1, 0,  2, 1, 0, 1, 0, 1, 0);
    tbl[7]  = mk('b0001, 1, 0,  1, 1, 0, 1, 0, 1, 0);
    tbl[8]  = mk('b0000, 1, 0,  0, 1, 0, 1, 0, 1, 0);
    tbl[9]  = mk('b1000, 1, 0, 15, 1, 0, 1, 0, 1, 0);
    tbl[10] = mk('b0000, 1, 0,  0, 1, 1, 0, 0, 1, 0);
    tbl[11] = mk('b0001, 1, 0,  1, 1, 1, 0, 0, 1, 0);
    tbl[12] = mk('b0011, 1, 0,  2, 1, 1, 0, 0, 1, 0);
    tbl[13] = mk('b0110, 1, 0,  4, 1, 0, 0, 1, 1, 1);
    tbl[14] = mk('b0111, 1, 0,  5, 1, 1, 0, 0, 1, 1);
    tbl[15] = mk('b0110, 1, 0,  4, 1, 0, 1, 0, 1, 1);
    tbl[16] = mk('b0010, 1, 0,  3, 1, 0, 1, 0, 1, 1);
    tbl[17] = mk('b0011, 1, 0,  2, 1, 0, 1, 0, 1, 1);
    tbl[18] = mk('b0001, 1, 0,  1, 1, 0, 1, 0, 1, 1);
    tbl[19] = mk('b0000, 1, 0,  0, 1, 0, 1, 0, 1, 1);
    tbl[20] = mk('b0000, 0, 1,  0, 0, 0, 0, 0, 1, 0);
    tbl[21] = mk('b0101, 1, 0,  6, 1, 0, 0, 1, 1, 1);
    tbl[22] = mk('b1111, 1, 0, 10, 1, 0, 0, 1, 1, 2);
    tbl[23] = mk('b0010, 1, 0,  3, 1, 0, 0, 1, 0, 3);
    tbl[24] = mk('b0011, 1, 0,  2, 1, 0, 0, 0, 1, 3);
    tbl[25] = mk('b1100, 1, 0,  8, 1, 0, 0, 1, 1, 4);
    tbl[26] = mk('b1101, 1, 0,  9, 1, 1, 0, 0, 1, 4);
    tbl[27] = mk('b0000, 1, 0,  0, 1, 0, 0, 1, 1, 5);
    tbl[28] = mk('b0110, 1, 1,  4, 1, 0, 0, 1, 1, 1);
    tbl[29] = mk('b0000, 0, 1,  4, 0, 0, 0, 0, 1, 0);
    tbl[30] = mk('b1111, 1, 0, 10, 1, 0, 0, 1, 0, 1);
    tbl[31] = mk('b0101, 1, 0,  6, 1, 0, 0, 0, 1, 1);

    bus.gray_in    = '0;
    bus.gray_valid = 1'b0;
    bus.err_clr    = 1'b0;
    #12;
    compare(999, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      do_step(i, tbl[i]);
    end

    // Alternate jump / legal step so lock is held while the counter saturates.
    seq  = '{8, 9, 0, 1};
    ecnt = 1;
    for (int i = 0; i < 600; i++) begin
      b  = seq[i % 4];
      g  = b ^ (b >> 1);
      er = (i % 2 == 0);
      if (er && ecnt < 255) ecnt++;
      do_step(100 + i, mk(g, 1, 0, b, 1, er ? 0 : 1, 0, er ? 1 : 0, 1, ecnt));
    end
    chk("err_count_saturated", 800, int'(bus.err_count), 255);

    do_step(900, mk('b0100, 1, 0, 7, 1, 0, 0, 1, 1, 255));

    @(negedge clk);
    rst            = 1'b1;
    bus.gray_valid = 1'b0;
    #1;
    compare(901, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    do_step(902, mk('b0100, 1, 0, 7, 1, 0, 0, 0, 1, 0));
    do_step(903, mk('b0000, 0, 0, 7, 0, 0, 0, 0, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
